// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: emits a burst of exactly num_bits SCLK periods with a programmable half-period.
// Latency: busy rises 1 cycle after an accepted start; edge k lands at 1+k*(divider+1); done follows one idle half-period after the last edge.
// Backpressure: none; start is ignored while busy, and abort returns to idle on the next cycle.
//
// Ports:
//   clk_in, rst_in       clock and synchronous active-high reset
//   start, abort         burst request / immediate termination (abort wins)
//   divider, num_bits    half-period minus one, burst length in SCLK periods (latched at start)
//   cpol, cpha           SPI mode (latched at start; cpol drives the idle level while idle)
//   sclk                 serial clock
//   lead_stb, trail_stb  one-cycle pulses coincident with leading / trailing SCLK edges
//   sample_stb, shift_stb  mode-dependent selection of lead/trail strobes
//   busy, done           burst in progress / one-cycle normal completion pulse

module spi_sclk_gen #(
    parameter int DIV_BITS = 8,
    parameter int CNT_BITS = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start,
    input  logic                abort,
    input  logic [DIV_BITS-1:0] divider,
    input  logic [CNT_BITS-1:0] num_bits,
    input  logic                cpol,
    input  logic                cpha,
    output logic                sclk,
    output logic                lead_stb,
    output logic                trail_stb,
    output logic                sample_stb,
    output logic                shift_stb,
    output logic                busy,
    output logic                done
);

    // Edge counter holds up to 2*num_bits, hence one extra bit.
    localparam int EDGE_W = CNT_BITS + 1;
    localparam logic [EDGE_W-1:0]   EDGE_ONE = EDGE_W'(1);
    localparam logic [DIV_BITS-1:0] HP_ONE   = DIV_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic                sclk_q,    sclk_d;
    logic                lead_q,    lead_d;
    logic                trail_q,   trail_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [DIV_BITS-1:0] hp_cnt_q,  hp_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [DIV_BITS-1:0] div_q,     div_d;
    logic [CNT_BITS-1:0] nbits_q,   nbits_d;
    logic                cpol_q,    cpol_d;
    logic                cpha_q,    cpha_d;

    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        lead_d     = 1'b0;
        trail_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;

        case (state_q)
            ST_IDLE: begin
                // Idle level follows the live cpol so the line is correct before the first edge.
                sclk_d = cpol;
                if (start && !abort) begin
                    if (num_bits == '0) begin
                        // Empty burst: complete immediately without ever going busy.
                        done_d = 1'b1;
                    end else begin
                        div_d      = divider;
                        nbits_d    = num_bits;
                        cpol_d     = cpol;
                        cpha_d     = cpha;
                        hp_cnt_d   = '0;
                        edge_cnt_d = '0;
                        busy_d     = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                end else if (hp_cnt_q == div_q) begin
                    hp_cnt_d   = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EDGE_ONE;
                    // Edges are numbered from 1: odd edges leave idle, even edges return.
                    if (!edge_cnt_q[0]) begin
                        lead_d = 1'b1;
                    end else begin
                        trail_d = 1'b1;
                    end
                    if (edge_cnt_d == {nbits_q, 1'b0}) begin
                        state_d = ST_TAIL;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + HP_ONE;
                end
            end

            ST_TAIL: begin
                // Hold the idle level for one more half-period before reporting done.
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                end else if (hp_cnt_q == div_q) begin
                    hp_cnt_d = '0;
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    sclk_d   = cpol_q;
                end else begin
                    hp_cnt_d = hp_cnt_q + HP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            sclk_q     <= 1'b0;
            lead_q     <= 1'b0;
            trail_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            div_q      <= '0;
            nbits_q    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            lead_q     <= lead_d;
            trail_q    <= trail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
        end
    end

    assign sclk       = sclk_q;
    assign lead_stb   = lead_q;
    assign trail_stb  = trail_q;
    assign busy       = busy_q;
    assign done       = done_q;
    // cpha=0 samples on the leading edge and shifts on the trailing one; cpha=1 swaps them.
    assign sample_stb = cpha_q ? trail_q : lead_q;
    assign shift_stb  = cpha_q ? lead_q  : trail_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
module tb_spi_sclk_gen;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start;
    logic       abort;
    logic [7:0] divider;
    logic [4:0] num_bits;
    logic       cpol;
    logic       cpha;
    logic       sclk, lead_stb, trail_stb, sample_stb, shift_stb, busy, done;

    spi_sclk_gen #(.DIV_BITS(8), .CNT_BITS(5)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start),
        .abort      (abort),
        .divider    (divider),
        .num_bits   (num_bits),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scenario tag and its start cycle, written by the stimulus only.
    int scen       = 0;
    int scen_start = 0;

    // Behavioural model: a burst is described by its start cycle and latched parameters;
    // every output is a closed-form function of the cycles elapsed since that start.
    int m_act = 0;
    int m_s, m_d, m_n, m_cpol, m_cpha;
    int e_sclk, e_lead, e_trail, e_busy, e_done, e_cpha;
    int t, rel, per, k, fin, accepted;

    int lead_cnt, trail_cnt, samp_rise, shift_fall, first_rel;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d (scen %0d)", name, act, exp, cyc, scen);
        end
    endtask

    task automatic eval_burst();
        rel = t - m_s;
        per = m_d + 1;
        fin = 1 + (2 * m_n + 1) * per;
        if (rel == fin) begin
            e_done = 1;
            e_busy = 0;
            e_sclk = m_cpol;
            m_act  = 0;
        end else begin
            e_busy = 1;
            k = (rel - 1) / per;
            if (k > 2 * m_n) k = 2 * m_n;
            e_sclk = m_cpol ^ (k % 2);
            if (((rel - 1) % per) == 0 && k >= 1 && k <= 2 * m_n) begin
                e_lead  = k % 2;
                e_trail = 1 - (k % 2);
            end
        end
    endtask

    always @(posedge clk_in) begin
        #1;
        cyc = cyc + 1;
        t = cyc;
        accepted = 0;
        e_lead = 0;
        e_trail = 0;
        e_done = 0;
        if (rst_in) begin
            m_act = 0;
            e_sclk = 0;
            e_busy = 0;
            e_cpha = 0;
        end else if (m_act != 0 && abort) begin
            m_act  = 0;
            e_busy = 0;
            e_sclk = m_cpol;
        end else if (m_act != 0) begin
            eval_burst();
        end else begin
            e_sclk = int'(cpol);
            e_busy = 0;
            if (start && !abort) begin
                if (num_bits == 5'd0) begin
                    e_done = 1;
                end else begin
                    m_act = 1; m_s = t - 1;
                    m_d = int'(divider); m_n = int'(num_bits);
                    m_cpol = int'(cpol); m_cpha = int'(cpha);
                    e_cpha = m_cpha;
                    accepted = 1;
                    eval_burst();
                end
            end
        end

        chk("sclk",   int'(sclk),      e_sclk);
        chk("lead",   int'(lead_stb),  e_lead);
        chk("trail",  int'(trail_stb), e_trail);
        chk("sample", int'(sample_stb), (e_cpha != 0) ? e_trail : e_lead);
        chk("shift",  int'(shift_stb),  (e_cpha != 0) ? e_lead : e_trail);
        chk("busy",   int'(busy),      e_busy);
        chk("done",   int'(done),      e_done);

        if (accepted != 0) begin
            lead_cnt = 0; trail_cnt = 0; samp_rise = 0; shift_fall = 0; first_rel = -1;
        end
        lead_cnt   += int'(lead_stb);
        trail_cnt  += int'(trail_stb);
        samp_rise  += int'(sample_stb && sclk);
        shift_fall += int'(shift_stb && !sclk);
        if (first_rel < 0 && (lead_stb || trail_stb)) first_rel = t - scen_start;

        // Hand-computed expectations that pin the model's timing.
        if (scen == 5 && t == scen_start + 21) begin
            chk("abort_busy",  int'(busy), 0);
            chk("abort_sclk",  int'(sclk), 0);
            chk("abort_stb",   int'(lead_stb | trail_stb), 0);
            chk("abort_done",  int'(done), 0);
        end
        if (e_done != 0) begin
            case (scen)
                2: begin
                    chk("s2_done_cycle", t - scen_start, 69);
                    chk("s2_lead_cnt",   lead_cnt, 8);
                    chk("s2_trail_cnt",  trail_cnt, 8);
                    chk("s2_sample_rise", samp_rise, 8);
                    chk("s2_shift_fall", shift_fall, 8);
                    chk("s2_first_edge", first_rel, 5);
                end
                3: begin
                    chk("s3_done_cycle", t - scen_start, 8);
                    chk("s3_sample_rise", samp_rise, 3);
                    chk("s3_first_edge", first_rel, 2);
                end
                4: chk("s4_done_cycle", t - scen_start, 1);
                6: begin
                    chk("s6_done_cycle", t - scen_start, 69);
                    chk("s6_lead_cnt",   lead_cnt, 8);
                    chk("s6_first_edge", first_rel, 5);
                end
                7: chk("s7_done_cycle", t - scen_start, 21);
                default: ;
            endcase
        end
    end

    task automatic go(input int d, input int n, input logic pol, input logic pha, input int sc);
        start      = 1'b1;
        divider    = 8'(d);
        num_bits   = 5'(n);
        cpol       = pol;
        cpha       = pha;
        scen       = sc;
        scen_start = cyc;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b1; abort = 1'b0;
        divider = 8'd3; num_bits = 5'd8; cpol = 1'b0; cpha = 1'b0;
        scen = 1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk_in);

        go(3, 8, 1'b0, 1'b0, 2);
        repeat (75) @(negedge clk_in);

        cpol = 1'b1;
        repeat (3) @(negedge clk_in);
        go(0, 3, 1'b1, 1'b1, 3);
        repeat (12) @(negedge clk_in);

        go(2, 0, 1'b0, 1'b0, 4);
        repeat (5) @(negedge clk_in);

        go(3, 8, 1'b0, 1'b0, 5);
        repeat (19) @(negedge clk_in);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        @(negedge clk_in);
        go(3, 2, 1'b0, 1'b0, 7);
        repeat (25) @(negedge clk_in);

        go(3, 8, 1'b0, 1'b0, 6);
        repeat (10) @(negedge clk_in);
        start = 1'b1; divider = 8'd7; num_bits = 5'd2; cpol = 1'b1; cpha = 1'b1;
        repeat (3) @(negedge clk_in);
        start = 1'b0;
        repeat (70) @(negedge clk_in);

        scen = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_in   = ($urandom_range(0, 499) == 0);
            start    = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 79) == 0);
            divider  = 8'($urandom_range(0, 4));
            num_bits = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
            cpol     = 1'($urandom_range(0, 1));
            cpha     = 1'($urandom_range(0, 1));
            @(negedge clk_in);
        end
        rst_in = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator; successor to the free-running power-of-two prescaler. Produces a burst of exactly N SCLK periods with programmable integer divider, CPOL/CPHA mode, per-edge sample/shift strobes and a start/busy/done handshake. Sits between the SPI master control FSM and the shift register.

Parameters:
DIV_BITS, 8, width of divider input; half-period = divider+1 clk_in cycles
CNT_BITS, 5, width of num_bits input; max burst = 2**CNT_BITS-1 bits

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous active-high reset
start  input  1  begin burst; sampled only in IDLE
abort  input  1  terminate burst immediately; wins over all other events
divider  input  DIV_BITS  half-period length minus one; latched at start
num_bits  input  CNT_BITS  number of SCLK periods in burst; latched at start
cpol  input  1  SCLK idle level; latched at start, tracked in IDLE
cpha  input  1  0: sample on leading edge, 1: sample on trailing edge; latched at start
sclk  output  1  serial clock
lead_stb  output  1  one-cycle pulse with each leading (idle->active) edge
trail_stb  output  1  one-cycle pulse with each trailing (active->idle) edge
sample_stb  output  1  lead_stb if cpha=0, trail_stb if cpha=1
shift_stb  output  1  trail_stb if cpha=0, lead_stb if cpha=1
busy  output  1  high from cycle after accepted start until done/abort
done  output  1  one-cycle pulse at normal burst completion

Behaviour:
- All outputs registered. Reset (rst_in=1 at clock edge): state IDLE, sclk=0, all strobes/busy/done=0, counters 0. Reset overrides start/abort in the same cycle.
- States: IDLE, RUN, TAIL.
- IDLE: sclk <= cpol every cycle. start=1 and abort=0 and num_bits!=0 -> latch divider/num_bits/cpol/cpha, half-period counter=0, edge counter=0, busy<=1, go RUN. start with num_bits=0 -> no SCLK activity, done<=1 next cycle, busy stays 0, remain IDLE.
- RUN: half-period counter increments each cycle; on reaching latched divider it clears, sclk toggles, edge counter increments, and lead_stb (odd edge, 1st,3rd,...) or trail_stb (even edge) asserts in the same cycle sclk shows its new value. Edge counter width CNT_BITS+1; after edge 2N go TAIL.
- TAIL: one further half-period (divider+1 cycles) with sclk=cpol; at its end done<=1, busy<=0 in the same cycle, go IDLE.
- Timing with start sampled at cycle 0: busy=1 at cycle 1; edge k (k=1..2N) visible at cycle 1+k*(divider+1); done pulse and busy=0 at cycle 1+(2N+1)*(divider+1).
- start while busy: ignored. Changes to divider/num_bits/cpol/cpha while busy: ignored until next start.
- abort in RUN or TAIL: next cycle state IDLE, busy=0, sclk=latched cpol, no strobe and no done that cycle, even if an edge was due. abort in IDLE: start ignored that cycle.
- divider=0: SCLK = clk_in/2, strobes every cycle alternating lead/trail.
- Strobes never assert in IDLE or TAIL. sample_stb/shift_stb are pure selection of registered strobes by latched cpha.

Test Plan:
- Reset with start held high -> sclk=0, busy=0, done=0, no strobes during and one cycle after reset.
- cpol=0, cpha=0, divider=3, num_bits=8, start at cycle 0 -> busy at 1, 16 edges at cycles 5,9,...,65, sclk rises on odd edges, 8 sample_stb on rising edges, 8 shift_stb on falling, done at cycle 69, busy low at 69.
- cpol=1, cpha=1, divider=0, num_bits=3 -> sclk idles 1, falls at 2, rises at 3, ..., 6 edges cycles 2-7, sample_stb on rising (trailing) edges only, done at 8.
- start with num_bits=0 -> done pulse next cycle, busy never high, sclk constant at cpol.
- abort at cycle 20 of the 8-bit divider=3 burst -> busy=0 and sclk=0 at cycle 21, no done, no strobe at 21; new start at 22 accepted normally.
- start reasserted and divider changed to 7 mid-burst -> ignored; edge spacing stays 4 cycles, single done.
